// File: rtl/riscv_pkg.sv
// riscv_pkg -- definitions shared by the memory stage and its load
// extension unit.
//   - funct3 encodings for loads and stores
//   - mem_state_t: state encoding of the data-memory handshake FSM
//   - is_misaligned(): natural-alignment test used by the optional
//     misalignment trap (MEM_MISALIGN_TRAP_EN)
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // funct3[1:0] encodes the access size for loads and stores alike:
  // 00 byte, 01 halfword, 10 word.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend -- selects the addressed byte/halfword lane of a 32-bit
// read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata  in  32  raw word returned by data memory
//   funct3 in   3  load type (LB/LH/LW/LBU/LHU)
//   offset in   2  byte offset within the word (address bits [1:0])
//   data   out 32  extended load result
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // offset[0] is ignored for halfwords; odd halfword offsets are either
    // trapped upstream or deliberately truncated.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline MEM stage: EX/MEM register, data-memory
// request/grant/rvalid handshake FSM, store lane steering, load
// extension and the MEM/WB register.
// Ports:
//   clk, reset                 clock, async active-high reset
//   *_ex                       EX-stage results/controls captured into EX/MEM
//   ALUResult_mem, rdAddr_mem,
//   RegWrite_mem               EX/MEM contents for forwarding
//   RegWriteData_wb, rdAddr_wb,
//   RegWrite_wb                MEM/WB contents
//   stall_mem                  holds PC, IF/ID and ID/EX while a memory op is outstanding
//   dmem_*                     data-memory request/response interface
//   misaligned_wb              misaligned-access flag aligned with MEM/WB
// Build option:
//   MEM_MISALIGN_TRAP_EN       misaligned LH/LHU/SH/LW/SW issue no request and
//                              retire in one cycle with misaligned_wb=1;
//                              when undefined, low address bits are ignored
//                              and misaligned_wb is tied 0.
//
// FSM states:
//   state | meaning
//   IDLE  | no request outstanding; requests immediately if an op is pending
//   REQ   | request raised but not yet granted; keep requesting
//   WAIT  | request granted; waiting for rvalid (read data / write ack)
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic [2:0]  funct3_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misaligned_wb
);

  logic [31:0] wdata_mem;
  logic [2:0]  funct3_mem;
  logic        memread_mem;
  logic        memwrite_mem;
  logic        memtoreg_mem;

  mem_state_t  state;
  mem_state_t  state_nxt;

  logic        mem_op;
  logic        misaligned;
  logic        pending;
  logic [1:0]  offset;
  logic [31:0] load_data;

  // EX/MEM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult_mem <= '0;
      wdata_mem     <= '0;
      rdAddr_mem    <= '0;
      funct3_mem    <= '0;
      RegWrite_mem  <= 1'b0;
      memread_mem   <= 1'b0;
      memwrite_mem  <= 1'b0;
      memtoreg_mem  <= 1'b0;
    end else if (!stall_mem) begin
      ALUResult_mem <= ALUResult_ex;
      wdata_mem     <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
      funct3_mem    <= funct3_ex;
      RegWrite_mem  <= RegWrite_ex;
      memread_mem   <= MemRead_ex;
      memwrite_mem  <= MemWrite_ex;
      memtoreg_mem  <= MemtoReg_ex;
    end
  end

  assign offset = ALUResult_mem[1:0];
  assign mem_op = memread_mem | memwrite_mem;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op & is_misaligned(funct3_mem, offset);
`else
  assign misaligned = 1'b0;
`endif

  // An op completes in the same cycle stall_mem drops, and EX/MEM reloads
  // on that edge, so no separate "done" flag is needed.
  assign pending = mem_op & ~misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    stall_mem = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          dmem_req  = 1'b1;
          stall_mem = 1'b1;
          state_nxt = dmem_gnt ? WAIT : REQ;
        end
      end
      REQ: begin
        if (pending) begin
          dmem_req  = 1'b1;
          stall_mem = 1'b1;
          if (dmem_gnt) state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        stall_mem = pending & ~dmem_rvalid;
        if (dmem_rvalid || !pending) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dmem_addr = {ALUResult_mem[31:2], 2'b00};
  assign dmem_we   = memwrite_mem;

  // Store data steering and byte enables; byte enables are only driven
  // while a memory op sits in EX/MEM so an idle stage presents 0000.
  always_comb begin
    dmem_wdata = wdata_mem;
    dmem_be    = 4'b0000;
    if (memwrite_mem) begin
      case (funct3_mem)
        F3_SB: begin
          dmem_wdata = {4{wdata_mem[7:0]}};
          dmem_be    = 4'b0001 << offset;
        end
        F3_SH: begin
          dmem_wdata = {2{wdata_mem[15:0]}};
          dmem_be    = 4'b0011 << {offset[1], 1'b0};
        end
        default: begin
          dmem_wdata = wdata_mem;
          dmem_be    = 4'b1111;
        end
      endcase
    end else if (memread_mem) begin
      dmem_be = 4'b1111;
    end
  end

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .funct3 (funct3_mem),
    .offset (offset),
    .data   (load_data)
  );

  // MEM/WB register; a stalled cycle inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteData_wb <= '0;
      rdAddr_wb       <= '0;
      RegWrite_wb     <= 1'b0;
    end else if (stall_mem) begin
      RegWriteData_wb <= '0;
      rdAddr_wb       <= '0;
      RegWrite_wb     <= 1'b0;
    end else begin
      RegWriteData_wb <= memtoreg_mem ? load_data : ALUResult_mem;
      rdAddr_wb       <= rdAddr_mem;
      RegWrite_wb     <= RegWrite_mem & ~misaligned;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          misaligned_wb <= 1'b0;
    else if (stall_mem) misaligned_wb <= 1'b0;
    else                misaligned_wb <= misaligned;
  end
`else
  assign misaligned_wb = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk input 1 (single clock); reset input 1 (asynchronous, active-high).
REQ-002 SHALL have EX-side inputs: ALUResult_ex 32, MemWriteData_ex 32, rdAddr_ex 5, funct3_ex 3, RegWrite_ex 1, MemRead_ex 1, MemWrite_ex 1, MemtoReg_ex 1 (captured EX results/controls).
REQ-003 SHALL have forwarding outputs: ALUResult_mem 32, rdAddr_mem 5, RegWrite_mem 1 (EX/MEM register contents).
REQ-004 SHALL have WB outputs: RegWriteData_wb 32, rdAddr_wb 5, RegWrite_wb 1 (MEM/WB register contents).
REQ-005 SHALL have output stall_mem 1: holds the PC, IF/ID and ID/EX registers upstream.
REQ-006 SHALL have data-memory outputs: dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32, dmem_be 4.
REQ-007 SHALL have data-memory inputs: dmem_gnt 1 (request accepted), dmem_rvalid 1 (read data or write ack), dmem_rdata 32.
REQ-008 SHALL have output misaligned_wb 1: misalignment flag, MEM/WB-aligned.

Function
REQ-009 The EX/MEM register SHALL load all EX inputs on the rising clk edge when stall_mem=0 and SHALL hold when stall_mem=1.
REQ-010 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-011 A memory op is pending when the EX/MEM copy of MemRead or MemWrite is 1 and not yet completed.
REQ-012 dmem_req SHALL be 1, combinationally, in IDLE or REQ while an op is pending.
REQ-013 FSM transitions: dmem_gnt=1 moves to WAIT; dmem_gnt=0 in IDLE moves to REQ; dmem_rvalid=1 in WAIT completes the op and returns to IDLE.
REQ-014 dmem_rvalid SHALL be ignored outside WAIT.
REQ-015 stall_mem SHALL equal pending AND NOT (state==WAIT AND dmem_rvalid); minimum load/store cost is 1 stall cycle (gnt in cycle k, rvalid in k+1).
REQ-016 Non-memory ops SHALL pass EX/MEM to MEM/WB in 1 cycle with stall_mem=0.
REQ-017 While stall_mem=1, MEM/WB SHALL load a bubble (RegWrite_wb=0, misaligned_wb=0).
REQ-018 dmem_addr SHALL be {ALUResult_mem[31:2],2'b00}; dmem_we SHALL equal the MemWrite copy.
REQ-019 Store lanes, a=ALUResult_mem[1:0]: SB replicates byte ×4, be=0001<<a; SH replicates halfword ×2, be=0011<<{a[1],0}; SW be=1111; loads be=1111.
REQ-020 Loads SHALL extract the lane selected by a: LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits; this is combinational on dmem_rdata at completion.
REQ-021 RegWriteData_wb SHALL be the extracted load data if MemtoReg, else ALUResult_mem.
REQ-022 Load-use hazards SHALL NOT be detected here; upstream hazard logic owns them.
REQ-023 rdAddr 0 with RegWrite=1 SHALL pass unchanged; x0 masking belongs to the register file.

Reset
REQ-024 reset=1 SHALL clear immediately: state=IDLE, all EX/MEM and MEM/WB fields=0, all outputs 0 (dmem_be=0000), including mid-transaction.
REQ-025 A dmem_rvalid arriving after reset SHALL be discarded.

Configuration
REQ-026 Macro MEM_MISALIGN_TRAP_EN defined: misaligned LH/LHU/SH (a[0]=1) or LW/SW (a!=00) SHALL issue no request, complete in 1 cycle with RegWrite_wb=0, and pulse misaligned_wb=1.
REQ-027 Macro MEM_MISALIGN_TRAP_EN undefined: low offending bits SHALL be ignored per REQ-019/020, and misaligned_wb SHALL be tied 0.

Structure
REQ-028 Shared package riscv_pkg SHALL hold the funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010) and the FSM state enum.
REQ-029 One sub-module load_extend SHALL implement lane select and sign/zero extension (REQ-020).

Verification
REQ-030 Bench SHALL cover: ALU op rd=5, result 0x1234 -> RegWrite_wb=1, RegWriteData_wb=0x1234 next cycle, stall_mem never 1.
REQ-031 Bench SHALL cover: LB, addr 0x103, gnt same cycle, rvalid next, rdata 0x80FFFFFF -> stall_mem=1 for 1 cycle, RegWriteData_wb=0xFFFFFF80.
REQ-032 Bench SHALL cover: SH, addr 0x102, data 0x0000BEEF -> dmem_addr=0x100, be=1100, wdata=0xBEEFBEEF, we=1.
REQ-033 Bench SHALL cover: LW with gnt delayed 3 cycles and rvalid 2 cycles later -> stall_mem high throughout, bubbles in WB, correct data once.
REQ-034 Bench SHALL cover: reset asserted in WAIT, then stray rvalid -> all outputs 0, state IDLE, no WB write.
REQ-035 Bench SHALL cover, with MEM_MISALIGN_TRAP_EN: LW at 0x101 -> dmem_req stays 0, misaligned_wb=1 for 1 cycle, RegWrite_wb=0.
